decode_cycle: RTL

Second stage of the five-stage RV32I pipeline. It takes the IF/ID outputs of the fetch stage (InstrD, PCD, PCPlus4D) and decodes the instruction into control signals. It reads the 32x32 register file, which it owns and which the writeback stage writes, sign-extends the immediate, and registers everything into the ID/EX boundary for the execute stage. A taken-branch flush from execute turns the ID/EX contents into a bubble.

---
 rtl/decode_cycle.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/decode_cycle.sv
// RV32I decode stage: field extraction, main/ALU decode, immediate extension,
// register file with write-through bypass, and the ID/EX pipeline register.
module decode_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        ALUSrcE,
    output logic        MemWriteE,
    output logic        ResultSrcE,
    output logic        BranchE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1_E,
    output logic [31:0] RD2_E,
    output logic [31:0] Imm_Ext_E,
    output logic [4:0]  RS1_E,
    output logic [4:0]  RS2_E,
    output logic [4:0]  RD_E,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E
);

    typedef struct packed {
        logic        reg_write;
        logic        alu_src;
        logic        mem_write;
        logic        result_src;
        logic        branch;
        logic [2:0]  alu_ctl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc4;
    } idex_t;

    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        funct7b5;

    assign op       = InstrD[6:0];
    assign rd       = InstrD[11:7];
    assign funct3   = InstrD[14:12];
    assign rs1      = InstrD[19:15];
    assign rs2      = InstrD[24:20];
    assign funct7b5 = InstrD[30];

    logic       reg_write, alu_src, mem_write, result_src, branch;
    logic [1:0] imm_src, alu_op;
    logic [2:0] alu_ctl;
    logic [31:0] imm_ext, rd1, rd2;

    always_comb begin
        reg_write  = 1'b0;
        imm_src    = 2'b00;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        result_src = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        unique case (op)
            7'b0000011: begin reg_write = 1'b1; alu_src = 1'b1; result_src = 1'b1; end
            7'b0100011: begin imm_src = 2'b01; alu_src = 1'b1; mem_write = 1'b1; end
            7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
            7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
            7'b1100011: begin imm_src = 2'b10; branch = 1'b1; alu_op = 2'b01; end
            default: ;
        endcase
    end

    always_comb begin
        alu_ctl = 3'b000;
        unique case (alu_op)
            2'b01: alu_ctl = 3'b001;
            2'b10: begin
                unique case (funct3)
                    3'b000: alu_ctl = (op == 7'b0110011 && funct7b5) ? 3'b001 : 3'b000;
                    3'b010: alu_ctl = 3'b101;
                    3'b110: alu_ctl = 3'b011;
                    3'b111: alu_ctl = 3'b010;
                    default: alu_ctl = 3'b000;
                endcase
            end
            default: alu_ctl = 3'b000;
        endcase
    end

    always_comb begin
        imm_ext = '0;
        unique case (imm_src)
            2'b00: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
            2'b01: imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            2'b10: imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                              InstrD[11:8], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    // Register file; x0 is never written so it stays zero.
    logic [31:0] rf_q [32];
    logic        wr_en;

    assign wr_en = RegWriteW && (RDW != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wr_en) begin
            rf_q[RDW] <= ResultW;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0) rd1 = (wr_en && RDW == rs1) ? ResultW : rf_q[rs1];
        if (rs2 != 5'd0) rd2 = (wr_en && RDW == rs2) ? ResultW : rf_q[rs2];
    end

    idex_t idex_d, idex_q, idex_out;

    always_comb begin
        idex_d = '0;
        if (!FlushE) begin
            idex_d = '{reg_write: reg_write, alu_src: alu_src, mem_write: mem_write,
                       result_src: result_src, branch: branch, alu_ctl: alu_ctl,
                       rd1: rd1, rd2: rd2, imm: imm_ext, rs1: rs1, rs2: rs2, rd: rd,
                       pc: PCD, pc4: PCPlus4D};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idex_q <= '0;
        else      idex_q <= idex_d;
    end

    // Outputs are gated by reset so they read zero without waiting for a clock.
    assign idex_out    = rst ? idex_q : '0;

    assign RegWriteE   = idex_out.reg_write;
    assign ALUSrcE     = idex_out.alu_src;
    assign MemWriteE   = idex_out.mem_write;
    assign ResultSrcE  = idex_out.result_src;
    assign BranchE     = idex_out.branch;
    assign ALUControlE = idex_out.alu_ctl;
    assign RD1_E       = idex_out.rd1;
    assign RD2_E       = idex_out.rd2;
    assign Imm_Ext_E   = idex_out.imm;
    assign RS1_E       = idex_out.rs1;
    assign RS2_E       = idex_out.rs2;
    assign RD_E        = idex_out.rd;
    assign PCE         = idex_out.pc;
    assign PCPlus4E    = idex_out.pc4;

endmodule
